// File: rtl/mips_mc_pkg.sv
// Shared constants for the multi-cycle MIPS control slice: opcodes, funct codes,
// ULA operation codes, mux encodings and the control FSM state enum.
package mips_mc_pkg;

  localparam int unsigned StateW = 4;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  // ULA operation codes, identical to the ULA's own decode
  localparam logic [3:0] UlaAnd = 4'b0000;
  localparam logic [3:0] UlaOr  = 4'b0001;
  localparam logic [3:0] UlaAdd = 4'b0010;
  localparam logic [3:0] UlaSub = 4'b0110;
  localparam logic [3:0] UlaSlt = 4'b0111;
  localparam logic [3:0] UlaNor = 4'b1100;

  // ULA B operand select
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // Next-PC select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // Request from the FSM to the ULA control decoder
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } aluop_e;

  typedef enum logic [StateW-1:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StWbMem,
    StMemWr,
    StRExec,
    StWbR,
    StBranch,
    StJump,
    StAddiExec,
    StAddiWb
  } state_e;

endpackage

// File: rtl/mips_mc_if.sv
// Control bundle between the multi-cycle control FSM and the datapath.
// master = control unit, slave = datapath (or bench).
interface mips_mc_if #(
  parameter int unsigned STATE_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               flagz;
  logic               pc_en;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         pc_source;
  logic [3:0]         ULAoperation;
  logic               illegal_op;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, funct, flagz,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, ULAoperation, illegal_op,
           state_dbg
  );

  modport slave (
    output opcode, funct, flagz,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, ULAoperation, illegal_op,
           state_dbg
  );
endinterface

// File: rtl/mips_ula_control.sv
// ULA control decoder: maps the FSM's ADD/SUB/funct request to a ULA opcode
// and flags funct codes the datapath does not implement.
module mips_ula_control
  import mips_mc_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ula_op_o,
  output logic       funct_bad_o
);

  // Decode request; unknown funct falls back to ADD so the ULA never sees X
  always_comb begin
    ula_op_o    = UlaAdd;
    funct_bad_o = 1'b0;
    unique case (aluop_i)
      AluOpAdd: ula_op_o = UlaAdd;
      AluOpSub: ula_op_o = UlaSub;
      AluOpFunct: begin
        case (funct_i)
          FnAdd:   ula_op_o = UlaAdd;
          FnSub:   ula_op_o = UlaSub;
          FnAnd:   ula_op_o = UlaAnd;
          FnOr:    ula_op_o = UlaOr;
          FnNor:   ula_op_o = UlaNor;
          FnSlt:   ula_op_o = UlaSlt;
          default: funct_bad_o = 1'b1;
        endcase
      end
      default: ula_op_o = UlaAdd;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM with folded-in ULA control.
// Optional: define MIPS_MC_BNE_EN to decode bne (opcode 0x05).
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic clk,
  input  logic reset,
  mips_mc_if.master bus
);

  state_e     state_q, state_d;
  logic       funct_bad_q, funct_bad_d;
  aluop_e     aluop;
  logic [3:0] ula_op;
  logic       ula_bad;

  // Ungated decode; strobes are masked by reset below
  logic       pc_en_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c, illegal_c;
  logic       iord_c, reg_dst_c, mem_to_reg_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, pc_source_c;

`ifdef MIPS_MC_BNE_EN
  // Branch type captured in DECODE: 1 = bne, 0 = beq
  logic bne_q, bne_d;
`endif

  mips_ula_control u_ula_control (
    .aluop_i     (aluop),
    .funct_i     (bus.funct),
    .ula_op_o    (ula_op),
    .funct_bad_o (ula_bad)
  );

  // State and per-instruction flags; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFetch;
      funct_bad_q <= 1'b0;
`ifdef MIPS_MC_BNE_EN
      bne_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      funct_bad_q <= funct_bad_d;
`ifdef MIPS_MC_BNE_EN
      bne_q       <= bne_d;
`endif
    end
  end

  // Next state and Moore output decode
  always_comb begin
    state_d      = state_q;
    funct_bad_d  = funct_bad_q;
    pc_en_c      = 1'b0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SrcBReg;
    pc_source_c  = PcSrcAlu;
    aluop        = AluOpAdd;
    illegal_c    = 1'b0;
`ifdef MIPS_MC_BNE_EN
    bne_d        = bne_q;
`endif
    unique case (state_q)
      StFetch: begin
        mem_read_c  = 1'b1;
        ir_write_c  = 1'b1;
        alu_src_b_c = SrcBFour;
        pc_en_c     = 1'b1;
        state_d     = StDecode;
      end
      StDecode: begin
        // Branch target computed speculatively into ALUOut
        alu_src_b_c = SrcBImmSh;
        case (bus.opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRExec;
          OpBeq: begin
            state_d = StBranch;
`ifdef MIPS_MC_BNE_EN
            bne_d   = 1'b0;
`endif
          end
`ifdef MIPS_MC_BNE_EN
          OpBne: begin
            state_d = StBranch;
            bne_d   = 1'b1;
          end
`endif
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default: begin
            illegal_c = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SrcBImm;
        state_d     = (bus.opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        iord_c     = 1'b1;
        mem_read_c = 1'b1;
        state_d    = StWbMem;
      end
      StWbMem: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        state_d      = StFetch;
      end
      StMemWr: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
        state_d     = StFetch;
      end
      StRExec: begin
        alu_src_a_c = 1'b1;
        aluop       = AluOpFunct;
        illegal_c   = ula_bad;
        funct_bad_d = ula_bad;
        state_d     = StWbR;
      end
      StWbR: begin
        reg_dst_c   = 1'b1;
        reg_write_c = ~funct_bad_q;
        state_d     = StFetch;
      end
      StBranch: begin
        alu_src_a_c = 1'b1;
        aluop       = AluOpSub;
        pc_source_c = PcSrcAluOut;
`ifdef MIPS_MC_BNE_EN
        pc_en_c     = bne_q ? ~bus.flagz : bus.flagz;
`else
        pc_en_c     = bus.flagz;
`endif
        state_d     = StFetch;
      end
      StJump: begin
        pc_source_c = PcSrcJump;
        pc_en_c     = 1'b1;
        state_d     = StFetch;
      end
      StAddiExec: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SrcBImm;
        state_d     = StAddiWb;
      end
      StAddiWb: begin
        reg_write_c = 1'b1;
        state_d     = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Strobes drop combinationally on reset so nothing writes after the assertion edge
  assign bus.pc_en        = pc_en_c & ~reset;
  assign bus.mem_read     = mem_read_c & ~reset;
  assign bus.mem_write    = mem_write_c & ~reset;
  assign bus.ir_write     = ir_write_c & ~reset;
  assign bus.reg_write    = reg_write_c & ~reset;
  assign bus.illegal_op   = illegal_c & ~reset;
  assign bus.iord         = iord_c;
  assign bus.reg_dst      = reg_dst_c;
  assign bus.mem_to_reg   = mem_to_reg_c;
  assign bus.alu_src_a    = alu_src_a_c;
  assign bus.alu_src_b    = alu_src_b_c;
  assign bus.pc_source    = pc_source_c;
  assign bus.ULAoperation = ula_op;
  assign bus.state_dbg    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: directed vector table, hand-written
// reset sequences and random instructions checked against an instruction-level model.
module tb_mips_mc_control;
  import mips_mc_pkg::*;

`ifdef MIPS_MC_BNE_EN
  localparam bit BneEn = 1'b1;
`else
  localparam bit BneEn = 1'b0;
`endif

  logic clk;
  logic reset;
  int   test_cnt;
  int   fail_cnt;

  mips_mc_if #(.STATE_W(4)) bus ();

  mips_mc_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic [3:0] ula;
    logic       ill;
  } rec_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    int         ill_n;
    logic [3:0] ula2;
    logic       pcen2;
  } vec_t;

  rec_t exp_q[$];
  vec_t vecs[$];

  function automatic rec_t sample();
    rec_t r;
    r.st         = bus.state_dbg;
    r.pc_en      = bus.pc_en;
    r.iord       = bus.iord;
    r.mem_read   = bus.mem_read;
    r.mem_write  = bus.mem_write;
    r.ir_write   = bus.ir_write;
    r.reg_dst    = bus.reg_dst;
    r.mem_to_reg = bus.mem_to_reg;
    r.reg_write  = bus.reg_write;
    r.alu_src_a  = bus.alu_src_a;
    r.src_b      = bus.alu_src_b;
    r.pc_src     = bus.pc_source;
    r.ula        = bus.ULAoperation;
    r.ill        = bus.illegal_op;
    return r;
  endfunction

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string name, input int cyc, input rec_t act, input rec_t exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Instruction-level model: the list of per-cycle control outputs for one instruction
  task automatic build_exp(input logic [5:0] op, input logic [5:0] fn, input logic z);
    rec_t b;
    rec_t r;
    logic legal;
    logic [3:0] rula;
    logic rbad;
    b = '0;
    b.ula = 4'b0010;
    exp_q.delete();
    r = b; r.st = StFetch; r.pc_en = 1; r.mem_read = 1; r.ir_write = 1; r.src_b = 2'b01;
    exp_q.push_back(r);
    legal = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04) ||
            (op == 6'h02) || (op == 6'h08) || (BneEn && op == 6'h05);
    r = b; r.st = StDecode; r.src_b = 2'b11; r.ill = ~legal;
    exp_q.push_back(r);
    if (!legal) return;
    case (op)
      6'h23, 6'h2B: begin
        r = b; r.st = StMemAdr; r.alu_src_a = 1; r.src_b = 2'b10;
        exp_q.push_back(r);
        if (op == 6'h23) begin
          r = b; r.st = StMemRd; r.iord = 1; r.mem_read = 1;
          exp_q.push_back(r);
          r = b; r.st = StWbMem; r.mem_to_reg = 1; r.reg_write = 1;
          exp_q.push_back(r);
        end else begin
          r = b; r.st = StMemWr; r.iord = 1; r.mem_write = 1;
          exp_q.push_back(r);
        end
      end
      6'h00: begin
        rbad = 0;
        case (fn)
          6'h20: rula = 4'b0010;
          6'h22: rula = 4'b0110;
          6'h24: rula = 4'b0000;
          6'h25: rula = 4'b0001;
          6'h27: rula = 4'b1100;
          6'h2A: rula = 4'b0111;
          default: begin rula = 4'b0010; rbad = 1; end
        endcase
        r = b; r.st = StRExec; r.alu_src_a = 1; r.ula = rula; r.ill = rbad;
        exp_q.push_back(r);
        r = b; r.st = StWbR; r.reg_dst = 1; r.reg_write = ~rbad;
        exp_q.push_back(r);
      end
      6'h04, 6'h05: begin
        r = b; r.st = StBranch; r.alu_src_a = 1; r.ula = 4'b0110; r.pc_src = 2'b01;
        r.pc_en = (op == 6'h05) ? ~z : z;
        exp_q.push_back(r);
      end
      6'h02: begin
        r = b; r.st = StJump; r.pc_src = 2'b10; r.pc_en = 1;
        exp_q.push_back(r);
      end
      default: begin
        r = b; r.st = StAddiExec; r.alu_src_a = 1; r.src_b = 2'b10;
        exp_q.push_back(r);
        r = b; r.st = StAddiWb; r.reg_write = 1;
        exp_q.push_back(r);
      end
    endcase
  endtask

  // Runs one instruction from FETCH, checking every cycle; cycle budget of 8
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, output int lat, output int ill_n,
                           output logic [3:0] ula2, output logic pcen2);
    rec_t a;
    bus.opcode = op;
    bus.funct  = fn;
    bus.flagz  = z;
    build_exp(op, fn, z);
    lat = 0; ill_n = 0; ula2 = 4'h0; pcen2 = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      a = sample();
      if (cyc < exp_q.size()) chk_rec(name, cyc, a, exp_q[cyc]);
      if (a.ill) ill_n++;
      if (cyc == 2) begin ula2 = a.ula; pcen2 = a.pc_en; end
      @(posedge clk);
      @(negedge clk);
      lat = cyc + 1;
      if (bus.state_dbg == StFetch) break;
    end
    if (bus.state_dbg != StFetch) begin
      chk_val({name, " timeout"}, 32'(bus.state_dbg), 32'(StFetch));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
    end
  endtask

  int         lat, ill_n;
  logic [3:0] ula2;
  logic       pcen2;
  logic [5:0] rop, rfn;
  logic       rz;

  initial begin
    test_cnt = 0;
    fail_cnt = 0;
    reset = 1'b1;
    bus.opcode = 6'h00;
    bus.funct  = 6'h20;
    bus.flagz  = 1'b0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_val("reset state", 32'(bus.state_dbg), 32'(StFetch));
      chk_val("reset strobes", {29'd0, bus.pc_en, bus.ir_write, bus.mem_read}, 32'd0);
      chk_val("reset ula", {28'd0, bus.ULAoperation}, 32'h2);
    end
    reset = 1'b0;
    #1;
    chk_val("post-reset state", 32'(bus.state_dbg), 32'(StFetch));
    chk_val("post-reset strobes", {29'd0, bus.pc_en, bus.ir_write, bus.mem_read}, 32'd7);

    // Directed vector table
    vecs.push_back('{"lw",      6'h23, 6'h00, 1'b0, 5, 0, 4'b0010, 1'b0});
    vecs.push_back('{"sw",      6'h2B, 6'h00, 1'b0, 4, 0, 4'b0010, 1'b0});
    vecs.push_back('{"add",     6'h00, 6'h20, 1'b0, 4, 0, 4'b0010, 1'b0});
    vecs.push_back('{"sub",     6'h00, 6'h22, 1'b0, 4, 0, 4'b0110, 1'b0});
    vecs.push_back('{"and",     6'h00, 6'h24, 1'b0, 4, 0, 4'b0000, 1'b0});
    vecs.push_back('{"or",      6'h00, 6'h25, 1'b0, 4, 0, 4'b0001, 1'b0});
    vecs.push_back('{"nor",     6'h00, 6'h27, 1'b0, 4, 0, 4'b1100, 1'b0});
    vecs.push_back('{"slt",     6'h00, 6'h2A, 1'b0, 4, 0, 4'b0111, 1'b0});
    vecs.push_back('{"badfn",   6'h00, 6'h3F, 1'b0, 4, 1, 4'b0010, 1'b0});
    vecs.push_back('{"beq z1",  6'h04, 6'h00, 1'b1, 3, 0, 4'b0110, 1'b1});
    vecs.push_back('{"beq z0",  6'h04, 6'h00, 1'b0, 3, 0, 4'b0110, 1'b0});
    vecs.push_back('{"j",       6'h02, 6'h00, 1'b0, 3, 0, 4'b0010, 1'b1});
    vecs.push_back('{"addi",    6'h08, 6'h00, 1'b0, 4, 0, 4'b0010, 1'b0});
    vecs.push_back('{"illegal", 6'h3F, 6'h00, 1'b0, 2, 1, 4'b0010, 1'b0});
`ifdef MIPS_MC_BNE_EN
    vecs.push_back('{"bne z0",  6'h05, 6'h00, 1'b0, 3, 0, 4'b0110, 1'b1});
    vecs.push_back('{"bne z1",  6'h05, 6'h00, 1'b1, 3, 0, 4'b0110, 1'b0});
`else
    vecs.push_back('{"bne off", 6'h05, 6'h00, 1'b0, 2, 1, 4'b0010, 1'b0});
`endif
    foreach (vecs[i]) begin
      run_instr(vecs[i].name, vecs[i].op, vecs[i].fn, vecs[i].z, lat, ill_n, ula2, pcen2);
      chk_val({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
      chk_val({vecs[i].name, " illegal cycles"}, 32'(ill_n), 32'(vecs[i].ill_n));
      if (vecs[i].lat >= 3) begin
        chk_val({vecs[i].name, " ula step3"}, {28'd0, ula2}, {28'd0, vecs[i].ula2});
        chk_val({vecs[i].name, " pc_en step3"}, {31'd0, pcen2}, {31'd0, vecs[i].pcen2});
      end
    end

    // Asynchronous reset in the MEM_WR cycle of sw
    bus.opcode = 6'h2B;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk_val("sw memwr state", 32'(bus.state_dbg), 32'(StMemWr));
    chk_val("sw memwr strobe", {31'd0, bus.mem_write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_val("async rst mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk_val("async rst state", 32'(bus.state_dbg), 32'(StFetch));
    @(negedge clk);
    chk_val("rst hold strobes", {27'd0, bus.mem_write, bus.mem_read, bus.reg_write,
                                 bus.pc_en, bus.ir_write}, 32'd0);
    reset = 1'b0;
    #1;
    chk_val("rst release state", 32'(bus.state_dbg), 32'(StFetch));
    chk_val("rst release mem_read", {31'd0, bus.mem_read}, 32'd1);

    // Random instructions against the model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 8))
        0: rop = 6'h23;
        1: rop = 6'h2B;
        2, 3: rop = 6'h00;
        4: rop = 6'h04;
        5: rop = 6'h05;
        6: rop = 6'h02;
        7: rop = 6'h08;
        default: rop = 6'($urandom);
      endcase
      case ($urandom_range(0, 6))
        0: rfn = 6'h20;
        1: rfn = 6'h22;
        2: rfn = 6'h24;
        3: rfn = 6'h25;
        4: rfn = 6'h27;
        5: rfn = 6'h2A;
        default: rfn = 6'($urandom);
      endcase
      rz = 1'($urandom);
      run_instr("random", rop, rfn, rz, lat, ill_n, ula2, pcen2);
      chk_val("random latency", 32'(lat), 32'(exp_q.size()));
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
